// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// default sizes, the BCD digit type and the converter state encoding.
package bcd_pkg;

  localparam int BCD_WIDTH  = 14;
  localparam int BCD_DIGITS = 4;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_t;

endpackage

// File: rtl/shift_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next decade.
module shift_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? bcd_digit_t'(i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one bit per clock, fixed
// latency, saturating to all nines when the value does not fit in DIGITS.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = BCD_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS + 1;
  localparam int BW = 4 * DIGITS;

  bcd_state_t         r_state;
  logic [CW-1:0]      r_cnt;
  logic [SW-1:0]      r_scratch;
  logic [WIDTH-1:0]   r_bin;
  logic [BW-1:0]      r_bcd;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;

  logic [BW-1:0]      w_adj;
  logic [SW-1:0]      w_shifted;
  logic               w_accept;
  logic               w_last;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
      shift_add3 u_add3 (
        .i_digit (r_scratch[4*gi +: 4]),
        .o_digit (w_adj[4*gi +: 4])
      );
    end
  endgenerate

  // The top bit is sticky: once anything spills past the last decade the
  // value can only grow, so it marks an out-of-range input for good.
  assign w_shifted = {r_scratch[SW-1] | w_adj[BW-1], w_adj[BW-2:0], r_bin[WIDTH-1]};
  assign w_accept  = start && (r_state != ST_SHIFT);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_scratch <= '0;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        ST_SHIFT: begin
          r_scratch <= w_shifted;
          r_bin     <= {r_bin[WIDTH-2:0], 1'b0};
          r_cnt     <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_ovf   <= r_scratch[SW-1];
          r_bcd   <= r_scratch[SW-1] ? {DIGITS{4'd9}} : r_scratch[BW-1:0];
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // A new request from IDLE or DONE overrides the state change above,
      // so a held start chains conversions without an idle cycle.
      if (w_accept) begin
        r_bin     <= bin;
        r_scratch <= '0;
        r_cnt     <= '0;
        r_state   <= ST_SHIFT;
        r_busy    <= 1'b1;
      end
    end
  end

  assign bcd      = r_bcd;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq with the default 14-bit,
// 4-digit configuration.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .bcd      (bcd),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Pulse start for one edge (edge 0), then count edges until done rises.
  task automatic run_conv(input logic [13:0] v, output int lat);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = ~v;
    lat   = 99;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  logic [13:0] vin  [7] = '{14'd0, 14'd1234, 14'd9999, 14'd10000, 14'd16383, 14'd5, 14'd255};
  logic [15:0] vexp [7] = '{16'h0000, 16'h1234, 16'h9999, 16'h9999, 16'h9999, 16'h0005, 16'h0255};
  logic        vovf [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int lat;
    int dones;
    int busy_hi;
    int done_edge;
    int done_edges[2];
    logic [15:0] done_bcd[2];

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset bcd", 32'(bcd), 32'h0);
    check("reset overflow", 32'(overflow), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_conv(vin[i], lat);
      check($sformatf("latency bin=%0d", vin[i]), 32'(lat), 32'd15);
      check($sformatf("bcd bin=%0d", vin[i]), 32'(bcd), 32'(vexp[i]));
      check($sformatf("overflow bin=%0d", vin[i]), 32'(overflow), 32'(vovf[i]));
    end

    // Start while busy is ignored: 42 accepted, 777 at edge 5 dropped.
    @(negedge clk);
    bin   = 14'd42;
    start = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    busy_hi   = 0;
    done_edge = 0;
    dones     = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k <= 14 && busy) busy_hi++;
      if (k == 15) check("busy low before edge 15", 32'(busy), 32'h0);
      if (k == 5) begin
        bin   = 14'd777;
        start = 1'b1;
      end
      if (k == 6) start = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        done_edge = k;
      end
    end
    check("busy high edges 1-14", 32'(busy_hi), 32'd14);
    check("ignored start done edge", 32'(done_edge), 32'd15);
    check("ignored start bcd", 32'(bcd), 32'h0042);
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("ignored start done count", 32'(dones), 32'd1);

    // Asynchronous reset aborts a conversion of 500 after edge 7.
    @(negedge clk);
    bin   = 14'd500;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("abort bcd cleared", 32'(bcd), 32'h0);
    check("abort busy cleared", 32'(busy), 32'h0);
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("abort no done", 32'(dones), 32'd0);
    check("abort bcd held", 32'(bcd), 32'h0);
    run_conv(14'd500, lat);
    check("after abort latency", 32'(lat), 32'd15);
    check("after abort bcd", 32'(bcd), 32'h0500);

    // Back-to-back with start held high: 12 then 34.
    @(negedge clk);
    bin   = 14'd12;
    start = 1'b1;
    @(posedge clk);
    #1;
    bin   = 14'd34;
    dones = 0;
    done_edges = '{0, 0};
    done_bcd   = '{16'h0, 16'h0};
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (dones < 2) begin
          done_edges[dones] = k;
          done_bcd[dones]   = bcd;
        end
        dones++;
        start = 1'b0;
      end
    end
    check("b2b done count", 32'(dones), 32'd2);
    check("b2b first done edge", 32'(done_edges[0]), 32'd15);
    check("b2b second done edge", 32'(done_edges[1]), 32'd30);
    check("b2b first bcd", 32'(done_bcd[0]), 32'h0012);
    check("b2b second bcd", 32'(done_bcd[1]), 32'h0034);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
